// File: rtl/core_pkg.sv
// Shared core definitions: register address width and the hazard-controller FSM states.
package core_pkg;

    localparam int REG_ADDR_W = 3;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_ENTER = 2'd2
    } state_t;

endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use detector: the decode instruction reads a register the ALU-stage load writes.
module load_use_detect
    import core_pkg::*;
(
    input  logic                  ex_mem_read_i,
    input  logic [REG_ADDR_W-1:0] ex_rdst_i,
    input  logic [REG_ADDR_W-1:0] id_rsrc1_i,
    input  logic [REG_ADDR_W-1:0] id_rsrc2_i,
    input  logic                  id_use1_i,
    input  logic                  id_use2_i,
    output logic                  hazard_o
);

    logic hit1;
    logic hit2;

    // R0 is an ordinary register, so a full compare is needed for every address.
    assign hit1     = id_use1_i & (id_rsrc1_i == ex_rdst_i);
    assign hit2     = id_use2_i & (id_rsrc2_i == ex_rdst_i);
    assign hazard_o = ex_mem_read_i & (hit1 | hit2);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencing controller: drives buffer enables/flushes for load-use, branch,
// two-cycle memory and interrupt-entry hazards.
module pipe_hazard_ctrl
    import core_pkg::*;
#(
    parameter int DRAIN_CYCLES = 3,
    parameter int CNT_W        = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [REG_ADDR_W-1:0] id_rsrc1,
    input  logic [REG_ADDR_W-1:0] id_rsrc2,
    input  logic                  id_use1,
    input  logic                  id_use2,
    input  logic                  ex_mem_read,
    input  logic [REG_ADDR_W-1:0] ex_rdst,
    input  logic                  ex_branch_taken,
    input  logic                  mem_two_cycle,
    input  logic                  int_req,
    output logic                  pc_enable,
    output logic                  fd_enable,
    output logic                  de_enable,
    output logic                  em_enable,
    output logic                  fd_flush,
    output logic                  de_flush,
    output logic                  int_ack,
    output logic                  busy,
    output state_t                dbg_state
);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             int_pend_q, int_pend_d;
    logic             mem_wait_q, mem_wait_d;
    logic             load_use;
    logic             freeze;

    load_use_detect u_lud (
        .ex_mem_read_i (ex_mem_read),
        .ex_rdst_i     (ex_rdst),
        .id_rsrc1_i    (id_rsrc1),
        .id_rsrc2_i    (id_rsrc2),
        .id_use1_i     (id_use1),
        .id_use2_i     (id_use2),
        .hazard_o      (load_use)
    );

    // The second bus cycle of a two-cycle op is the one with mem_wait_q set.
    assign freeze = mem_two_cycle & ~mem_wait_q;

    always_comb begin
        pc_enable  = 1'b1;
        fd_enable  = 1'b1;
        de_enable  = 1'b1;
        em_enable  = 1'b1;
        fd_flush   = 1'b0;
        de_flush   = 1'b0;
        int_ack    = 1'b0;
        state_d    = state_q;
        cnt_d      = cnt_q;
        int_pend_d = int_pend_q | int_req;
        mem_wait_d = 1'b0;

        if (!rst) begin
            if (freeze) begin
                pc_enable  = 1'b0;
                fd_enable  = 1'b0;
                de_enable  = 1'b0;
                em_enable  = 1'b0;
                mem_wait_d = 1'b1;
            end else if (ex_branch_taken) begin
                fd_flush = 1'b1;
                de_flush = 1'b1;
                if (state_q == ST_DRAIN) cnt_d = CNT_W'(DRAIN_CYCLES);
            end else if (load_use) begin
                pc_enable = 1'b0;
                fd_enable = 1'b0;
                de_flush  = 1'b1;
            end else begin
                unique case (state_q)
                    ST_RUN: begin
                        if (int_pend_q | int_req) begin
                            state_d = ST_DRAIN;
                            cnt_d   = CNT_W'(DRAIN_CYCLES);
                        end
                    end
                    ST_DRAIN: begin
                        pc_enable = 1'b0;
                        fd_flush  = 1'b1;
                        if (cnt_q != '0) cnt_d = cnt_q - CNT_W'(1);
                        if (cnt_q == CNT_W'(1)) state_d = ST_ENTER;
                    end
                    ST_ENTER: begin
                        int_ack    = 1'b1;
                        fd_flush   = 1'b1;
                        // A request arriving in the entry cycle itself must survive the clear.
                        int_pend_d = int_req;
                        state_d    = ST_RUN;
                    end
                    default: state_d = ST_RUN;
                endcase
            end
        end
    end

    assign busy      = (state_q != ST_RUN) & ~rst;
    assign dbg_state = state_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_RUN;
            cnt_q      <= '0;
            int_pend_q <= 1'b0;
            mem_wait_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            int_pend_q <= int_pend_d;
            mem_wait_q <= mem_wait_d;
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: directed hazard scenarios followed by random traffic,
// all checked cycle by cycle against a rule-level reference model.
module tb_pipe_hazard_ctrl;
    import core_pkg::*;

    localparam int DRAIN = 3;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] id_rsrc1, id_rsrc2, ex_rdst;
    logic       id_use1, id_use2, ex_mem_read, ex_branch_taken, mem_two_cycle, int_req;
    logic       pc_enable, fd_enable, de_enable, em_enable, fd_flush, de_flush, int_ack, busy;
    state_t     dbg_state;

    int n_vec  = 0;
    int n_miss = 0;
    logic [7:0] last_out;

    // reference model state
    int m_mode;   // 0 = running, 1 = draining, 2 = entering interrupt
    int m_left;   // drain bubbles still to be inserted
    bit m_pend;
    bit m_waited; // second cycle of a two-cycle memory op

    pipe_hazard_ctrl #(.DRAIN_CYCLES(DRAIN), .CNT_W(2)) dut (
        .clk(clk), .rst(rst),
        .id_rsrc1(id_rsrc1), .id_rsrc2(id_rsrc2), .id_use1(id_use1), .id_use2(id_use2),
        .ex_mem_read(ex_mem_read), .ex_rdst(ex_rdst), .ex_branch_taken(ex_branch_taken),
        .mem_two_cycle(mem_two_cycle), .int_req(int_req),
        .pc_enable(pc_enable), .fd_enable(fd_enable), .de_enable(de_enable), .em_enable(em_enable),
        .fd_flush(fd_flush), .de_flush(de_flush), .int_ack(int_ack), .busy(busy),
        .dbg_state(dbg_state)
    );

    // clock
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %b expected %b at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit model_load_use();
        logic [2:0] src [2];
        bit         used[2];
        src[0] = id_rsrc1; src[1] = id_rsrc2;
        used[0] = id_use1; used[1] = id_use2;
        if (!ex_mem_read) return 1'b0;
        foreach (src[i]) if (used[i] && src[i] == ex_rdst) return 1'b1;
        return 1'b0;
    endfunction

    // expected {pc_en, fd_en, de_en, em_en, fd_flush, de_flush, int_ack, busy}
    function automatic logic [7:0] model_out();
        if (rst) return 8'b1111_0000;
        if (mem_two_cycle && !m_waited) return {7'b0000_000, m_mode != 0};
        if (ex_branch_taken)            return {6'b1111_11, 1'b0, m_mode != 0};
        if (model_load_use())           return {6'b0011_01, 1'b0, m_mode != 0};
        if (m_mode == 1)                return 8'b0111_1001;
        if (m_mode == 2)                return 8'b1111_1011;
        return 8'b1111_0000;
    endfunction

    function automatic void model_update();
        bit pend_now;
        if (rst) begin
            m_mode = 0; m_left = 0; m_pend = 0; m_waited = 0;
            return;
        end
        pend_now = m_pend | int_req;
        if (mem_two_cycle && !m_waited) begin
            m_waited = 1;
            m_pend   = pend_now;
            return;
        end
        m_waited = 0;
        if (ex_branch_taken) begin
            if (m_mode == 1) m_left = DRAIN;
            m_pend = pend_now;
        end else if (model_load_use()) begin
            m_pend = pend_now;
        end else if (m_mode == 0) begin
            m_pend = pend_now;
            if (pend_now) begin m_mode = 1; m_left = DRAIN; end
        end else if (m_mode == 1) begin
            m_pend = pend_now;
            m_left = m_left - 1;
            if (m_left == 0) m_mode = 2;
        end else begin
            m_mode = 0;
            m_pend = int_req;
        end
    endfunction

    task automatic idle();
        rst = 0; id_rsrc1 = 0; id_rsrc2 = 0; ex_rdst = 0; id_use1 = 0; id_use2 = 0;
        ex_mem_read = 0; ex_branch_taken = 0; mem_two_cycle = 0; int_req = 0;
    endtask

    // inputs are already applied just after a posedge; sample mid-cycle, then advance
    task automatic step(input string tag);
        logic [7:0] got;
        #3;
        got = {pc_enable, fd_enable, de_enable, em_enable, fd_flush, de_flush, int_ack, busy};
        last_out = got;
        check(tag, got, model_out());
        @(posedge clk);
        model_update();
        #1;
    endtask

    initial begin
        int waited;
        m_mode = 0; m_left = 0; m_pend = 0; m_waited = 0;
        idle();
        rst = 1;
        @(posedge clk); #1;
        step("reset");
        step("reset");
        check("reset_outs", last_out, 8'b1111_0000);
        idle();
        step("idle");

        // load-use on rsrc2, then the load moves on, then same regs with use2 off
        ex_mem_read = 1; ex_rdst = 3; id_rsrc2 = 3; id_use2 = 1; id_rsrc1 = 5; id_use1 = 1;
        step("lu_hit");
        check("lu_stall", last_out, 8'b0011_0100);
        ex_mem_read = 0;
        step("lu_after");
        check("lu_release", last_out, 8'b1111_0000);
        ex_mem_read = 1; id_use2 = 0;
        step("lu_nouse");
        check("lu_nostall", last_out, 8'b1111_0000);
        // R0 is a real register
        ex_rdst = 0; id_rsrc1 = 0; id_use1 = 1;
        step("lu_r0");
        check("lu_r0_stall", last_out, 8'b0011_0100);
        idle();

        // two-cycle memory op with a branch alongside in its first cycle
        mem_two_cycle = 1; ex_branch_taken = 1;
        step("mem_c1");
        check("mem_freeze", last_out, 8'b0000_0000);
        step("mem_c2");
        check("mem_advance_branch", last_out, 8'b1111_1100);
        idle();
        step("mem_done");

        ex_branch_taken = 1;
        step("br");
        check("branch_flush", last_out, 8'b1111_1100);
        ex_branch_taken = 0;
        step("br_after");
        check("branch_once", last_out, 8'b1111_0000);

        // interrupt: three drain bubbles, then the entry cycle, counted from the request
        int_req = 1;
        step("int_req");
        int_req = 0;
        waited = 0;
        while (last_out[1] !== 1'b1 && waited < 20) begin
            step("int_wait");
            waited++;
            if (waited <= DRAIN) check("int_drain", last_out, 8'b0111_1001);
        end
        check("int_latency", 8'(waited), 8'(DRAIN + 1));
        step("int_back");
        check("int_run", last_out, 8'b1111_0000);

        // branch in the middle of a drain restarts the count
        int_req = 1;
        step("intb_req");
        int_req = 0;
        step("intb_d1");
        ex_branch_taken = 1;
        step("intb_br");
        ex_branch_taken = 0;
        waited = 0;
        while (last_out[1] !== 1'b1 && waited < 20) begin
            step("intb_wait");
            waited++;
        end
        check("intb_restart", 8'(waited), 8'(DRAIN + 1));
        step("intb_back");

        // request arrives during a freeze: latched, drain begins once the op completes
        mem_two_cycle = 1; int_req = 1;
        step("intf_freeze");
        int_req = 0;
        step("intf_c2");
        check("intf_c2_run", last_out, 8'b1111_0000);
        mem_two_cycle = 0;
        step("intf_drain");
        check("intf_drain", last_out, 8'b0111_1001);
        repeat (DRAIN + 2) step("intf_rest");

        // reset with two bubbles left abandons the interrupt
        int_req = 1;
        step("intr_req");
        int_req = 0;
        step("intr_cnt3");
        rst = 1;
        step("intr_rst");
        rst = 0;
        step("intr_post");
        check("intr_post_run", last_out, 8'b1111_0000);
        repeat (6) begin
            step("intr_quiet");
            check("intr_no_ack", {7'b0, last_out[1]}, 8'h00);
        end

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            rst             = ($urandom_range(0, 199) == 0);
            ex_rdst         = 3'($urandom_range(0, 7));
            id_rsrc1        = ($urandom_range(0, 1) == 1) ? ex_rdst : 3'($urandom_range(0, 7));
            id_rsrc2        = ($urandom_range(0, 1) == 1) ? ex_rdst : 3'($urandom_range(0, 7));
            id_use1         = 1'($urandom_range(0, 1));
            id_use2         = 1'($urandom_range(0, 1));
            ex_mem_read     = ($urandom_range(0, 9) < 3);
            ex_branch_taken = ($urandom_range(0, 9) == 0);
            mem_two_cycle   = ($urandom_range(0, 9) < 2);
            int_req         = ($urandom_range(0, 19) == 0);
            step("rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Pipeline sequencing controller for the 5-stage core.
- Generates the PC, fetch/decode, decode/ALU and ALU/memory buffer enables and flushes, so those buffers advance, freeze or take a bubble on the correct edge.
- Resolves four hazards:
  - load-use data hazards;
  - taken-branch squashes;
  - two-cycle memory operations (32-bit PC push/pop over the 16-bit data bus);
  - interrupt entry, which drains the pipeline before acknowledging.
- Sits beside the decode stage. It reads hazard information from decode, ALU and memory, and drives only buffer controls.

## Interface
Parameters:
- DRAIN_CYCLES, 3, bubble cycles inserted before `int_ack` so older instructions retire.
- CNT_W, 2, drain-counter width; must satisfy 2^CNT_W > DRAIN_CYCLES.

Ports:
- clk  in  1  core clock. State updates on posedge; buffers sample on negedge.
- rst  in  1  synchronous, active-high reset.
- id_rsrc1, id_rsrc2  in  3 each  source registers of the instruction in decode.
- id_use1, id_use2  in  1 each  the decode instruction actually reads rsrc1 / rsrc2.
- ex_mem_read  in  1  the instruction in the ALU stage is a load (POP/LDD).
- ex_rdst  in  3  destination register of the ALU-stage instruction.
- ex_branch_taken  in  1  branch/CALL/RET resolved taken in the ALU stage.
- mem_two_cycle  in  1  the memory-stage instruction needs two data-bus cycles. Held high while that instruction occupies the memory stage.
- int_req  in  1  external interrupt request; a single-cycle pulse is enough.
- pc_enable, fd_enable, de_enable, em_enable  out  1 each  advance the PC / fetch-decode / decode-ALU / ALU-memory buffers.
- fd_flush, de_flush  out  1 each  load a bubble (all-zero control fields) into fetch-decode / decode-ALU.
- int_ack  out  1  interrupt entry cycle; the fetch unit loads the vector.
- busy  out  1  FSM is not in RUN.

## Operation
Internal state:
- FSM with states RUN, DRAIN, ENTER.
- `mem_wait_q`, orthogonal to the FSM.
- Drain counter `cnt`.
- Sticky `int_pend`: set by `int_req`, cleared at ENTER.

Default outputs: all enables 1, flushes 0, `int_ack` 0.

Conditions are evaluated in priority order; the first match wins:
1. **rst**: FSM→RUN, `cnt`=0, `int_pend`=0, `mem_wait_q`=0. Outputs take the defaults above.
2. **Freeze**: `mem_two_cycle` & !`mem_wait_q`.
   - All four enables 0, flushes 0.
   - Set `mem_wait_q`.
   - FSM, `cnt` and `int_pend` are held; a new `int_req` is still latched.
   - Branch and load-use inputs are ignored, because they re-present next cycle.
   - Next cycle: `mem_wait_q`=1, so there is no freeze. `mem_wait_q` clears and the pipeline advances. Net effect is exactly one stall cycle per two-cycle instruction.
3. **Branch**: `ex_branch_taken`.
   - `fd_flush`=1, `de_flush`=1; enables stay 1.
   - In DRAIN, also reload `cnt`=DRAIN_CYCLES.
4. **Load-use**: `ex_mem_read` & ((`id_use1` & `id_rsrc1`==`ex_rdst`) | (`id_use2` & `id_rsrc2`==`ex_rdst`)).
   - `pc_enable`=0, `fd_enable`=0, `de_flush`=1.
   - Lasts one cycle only; the load has moved on by the next cycle.
5. **FSM**:
   - RUN: if `int_pend` | `int_req`, go to DRAIN with `cnt`=DRAIN_CYCLES.
   - DRAIN: `pc_enable`=0, `fd_flush`=1. Decrement `cnt`; when `cnt`==1, go to ENTER.
   - ENTER: `int_ack`=1, `pc_enable`=1, `fd_flush`=1. Clear `int_pend`; go to RUN.

Further rules:
- `int_req` arriving in DRAIN or ENTER sets `int_pend` and is serviced after returning to RUN.
- Register compares are full 3-bit equality; R0 is a real register, not a zero register.
- The counter never wraps: it is only decremented in DRAIN while ≥1.

## Timing
- Outputs are combinational from registered state plus current inputs. They settle within the high phase, before the negedge buffer capture.
- Reset values: FSM=RUN, `cnt`=0, `int_pend`=0, `mem_wait_q`=0. During reset all outputs take the default values given in Operation.
- Latencies:
  - load-use: 1 bubble;
  - branch: 2 squashed instructions, 0 stall;
  - two-cycle memory: 1 stall;
  - interrupt: `int_ack` DRAIN_CYCLES+1 cycles after the RUN cycle that sees the request, if nothing else intervenes.
- Asserting reset mid-DRAIN abandons the interrupt; `int_pend` is cleared.

## Structure
- Shared package `core_pkg` holds the FSM state typedef (RUN/DRAIN/ENTER) and the `REG_ADDR_W`=3 constant.
- One sub-module is natural: `load_use_detect`, purely combinational, containing the compare logic of rule 4. Everything else stays in the top.

## Test plan
- **Load-use:** `ex_mem_read`=1, `ex_rdst`=3, `id_rsrc2`=3, `id_use2`=1.
  - Expect for one cycle: `pc_enable`=0, `fd_enable`=0, `de_flush`=1.
  - Next cycle, with `ex_mem_read`=0: all defaults.
  - Repeat with `id_use2`=0: expect no stall.
- **Two-cycle memory:** `mem_two_cycle` high for 2 cycles.
  - Cycle 1: all enables 0.
  - Cycle 2: all enables 1.
  - Simultaneous `ex_branch_taken` in cycle 1: no flush until cycle 2.
- **Branch:** `ex_branch_taken` pulse in RUN. Expect `fd_flush`=`de_flush`=1 with all enables 1, for exactly one cycle.
- **Interrupt, default DRAIN_CYCLES=3:** `int_req` pulse in RUN.
  - Expect `busy`=1 with `pc_enable`=0 and `fd_flush`=1 for 3 cycles.
  - Then `int_ack`=1 for 1 cycle, then RUN.
  - A branch during DRAIN restarts the 3-cycle count.
- **Interrupt during freeze:** `int_req` arrives while `mem_two_cycle` freezes. `int_pend` is latched; DRAIN starts the cycle after the freeze.
- **Reset mid-DRAIN:** assert `rst` at `cnt`=2. Next cycle: RUN, `int_ack`=0, `busy`=0; the interrupt is not serviced.
